spi_cmd_sequencer: RTL and testbench

//  Upstream command stage for the 3-slave SPI master. Queues byte transactions
//  (slave select, RW, TX byte) in a FIFO and drives the master's CS/RW/data_in

---
 rtl/spi_cmd_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_fifo: circular FIFO for queued SPI byte commands, with an occupancy count.
// Latency: an accepted push shows up in count and rd_dat on the next cycle.
// Backpressure: full is asserted at count==DEPTH, and a push while full is ignored. There is no bypass.
module spi_cmd_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rd_dat  = mem[rd_ptr];

  // Storage array. No reset is needed because an entry is always written before it is read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // The pointers wrap modulo DEPTH for free because DEPTH is a power of two. A push and a pop in the same cycle leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// spi_cmd_sequencer: queues SPI byte commands and plays each one into the master as exactly one CS window.
// Latency: a command accepted in cycle t drives spi_cs from t+3 to t+2+BYTE_CYCLES. A read response is valid 2 cycles after the window at the earliest.
// Backpressure: cmd_ready drops while the FIFO is full. A held rsp_valid stalls the sequencer in WAIT_RSP, so no new window starts.
module spi_cmd_sequencer #(
  parameter  int DEPTH       = 4,
  parameter  int BYTE_CYCLES = 8,
  parameter  int GAP_CYCLES  = 2,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_cs,
  input  logic [1:0]    cmd_rw,
  input  logic [7:0]    cmd_data,
  output logic [1:0]    spi_cs,
  output logic [1:0]    spi_rw,
  output logic [7:0]    spi_tx_data,
  input  logic [7:0]    spi_rx_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic [1:0]    rsp_cs,
  output logic [CW-1:0] cmd_count,
  output logic          busy,
  output logic          err_drop
);

  typedef struct packed {
    logic [1:0] cs;
    logic [1:0] rw;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT    = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam int BW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(BYTE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // With no gap configured, a finished byte goes straight back to IDLE.
  localparam state_t AFTER_BYTE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t        state;
  state_t        state_nxt;
  cmd_t          cmd_in;
  cmd_t          head;
  logic          fifo_full;
  logic          fifo_pop;
  logic          shift_last;
  logic          rsp_slot;

  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_cnt_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_nxt;
  logic [7:0]    rx_hold;
  logic [7:0]    rx_hold_nxt;
  logic [1:0]    cur_cs;
  logic [1:0]    cur_cs_nxt;
  logic [1:0]    cur_rw;
  logic [1:0]    cur_rw_nxt;
  logic [1:0]    spi_cs_nxt;
  logic [1:0]    spi_rw_nxt;
  logic [7:0]    spi_tx_data_nxt;
  logic          rsp_valid_nxt;
  logic [7:0]    rsp_data_nxt;
  logic [1:0]    rsp_cs_nxt;
  logic          err_drop_nxt;

  assign cmd_in    = '{cs: cmd_cs, rw: cmd_rw, data: cmd_data};
  assign cmd_ready = !fifo_full;

  spi_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (cmd_valid),
    .wr_dat (cmd_in),
    .pop    (fifo_pop),
    .rd_dat (head),
    .full   (fifo_full),
    .count  (cmd_count)
  );

  assign shift_last = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
  // The response register can take a new byte when it is empty or is being drained this cycle.
  assign rsp_slot   = !rsp_valid || rsp_ready;
  assign busy       = (state != S_IDLE) || (cmd_count != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A command with cs==0 is dropped in LOAD and never opens a window.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (cmd_count != '0) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = (head.cs == 2'd0) ? S_IDLE : S_SHIFT;
      S_SHIFT:    if (bit_cnt == BIT_LAST) state_nxt = cur_rw[1] ? S_WAIT_RSP : AFTER_BYTE;
      S_WAIT_RSP: if (rsp_slot) state_nxt = AFTER_BYTE;
      S_GAP:      if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values. Every output is registered below, and spi_tx_data keeps its last byte outside SHIFT.
  always_comb begin
    fifo_pop        = 1'b0;
    bit_cnt_nxt     = bit_cnt;
    gap_cnt_nxt     = gap_cnt;
    rx_hold_nxt     = rx_hold;
    cur_cs_nxt      = cur_cs;
    cur_rw_nxt      = cur_rw;
    spi_cs_nxt      = spi_cs;
    spi_rw_nxt      = spi_rw;
    spi_tx_data_nxt = spi_tx_data;
    rsp_valid_nxt   = rsp_valid && !rsp_ready;
    rsp_data_nxt    = rsp_data;
    rsp_cs_nxt      = rsp_cs;
    err_drop_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        spi_cs_nxt = 2'd0;
        spi_rw_nxt = 2'd0;
      end
      S_LOAD: begin
        fifo_pop = 1'b1;
        if (head.cs == 2'd0) begin
          err_drop_nxt = 1'b1;
        end else begin
          spi_cs_nxt      = head.cs;
          spi_rw_nxt      = head.rw;
          spi_tx_data_nxt = head.data;
          cur_cs_nxt      = head.cs;
          cur_rw_nxt      = head.rw;
          bit_cnt_nxt     = '0;
        end
      end
      S_SHIFT: begin
        bit_cnt_nxt = bit_cnt + 1'b1;
        if (shift_last) begin
          rx_hold_nxt = spi_rx_data;
          spi_cs_nxt  = 2'd0;
          spi_rw_nxt  = 2'd0;
          gap_cnt_nxt = '0;
        end
      end
      S_WAIT_RSP: begin
        if (rsp_slot) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = rx_hold;
          rsp_cs_nxt    = cur_cs;
          gap_cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: begin
        spi_cs_nxt = 2'd0;
        spi_rw_nxt = 2'd0;
      end
    endcase
  end

  // Output and datapath registers. Reset drops any byte in flight and any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      rx_hold     <= '0;
      cur_cs      <= '0;
      cur_rw      <= '0;
      spi_cs      <= '0;
      spi_rw      <= '0;
      spi_tx_data <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_cs      <= '0;
      err_drop    <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      rx_hold     <= rx_hold_nxt;
      cur_cs      <= cur_cs_nxt;
      cur_rw      <= cur_rw_nxt;
      spi_cs      <= spi_cs_nxt;
      spi_rw      <= spi_rw_nxt;
      spi_tx_data <= spi_tx_data_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_cs      <= rsp_cs_nxt;
      err_drop    <= err_drop_nxt;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed bench for spi_cmd_sequencer with DEPTH=4, BYTE_CYCLES=8 and GAP_CYCLES=2.
// Inputs are driven at the falling edge and outputs are sampled at the next falling edge.
// A monitor records every spi_cs window (its fields, length and leading idle gap) for the multi-cycle checks.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_cs;
  logic [1:0] cmd_rw;
  logic [7:0] cmd_data;
  logic [1:0] spi_cs;
  logic [1:0] spi_rw;
  logic [7:0] spi_tx_data;
  logic [7:0] spi_rx_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_cs;
  logic [2:0] cmd_count;
  logic       busy;
  logic       err_drop;

  logic       rx_auto = 1'b0;
  logic [7:0] rx_man = 8'h00;
  logic [7:0] rx_auto_val = 8'h00;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       vld;
    logic [1:0] cs;
    logic [1:0] rw;
    logic [7:0] dat;
    logic       rrdy;
    logic [7:0] rx;
    logic [1:0] e_cs;
    logic [1:0] e_rw;
    logic [7:0] e_tx;
    logic       e_rv;
    logic [7:0] e_rd;
    logic [1:0] e_rcs;
    logic [2:0] e_cnt;
    logic       e_busy;
    logic       e_err;
    logic       e_crdy;
  } vec_t;

  typedef struct {
    logic [1:0] cs;
    logic [1:0] rw;
    logic [7:0] tx;
    int         len;
    int         gap;
  } win_t;

  vec_t tbl[$];
  win_t win_q[$];
  win_t cur_w;
  win_t sent_q[$];
  int   run_len = 0;
  int   idle_len = 0;
  int   win_started = 0;
  int   err_seen = 0;
  int   unstable = 0;

  assign spi_rx_data = rx_auto ? rx_auto_val : rx_man;

  always #5 clk = ~clk;

  spi_cmd_sequencer #(
    .DEPTH       (4),
    .BYTE_CYCLES (8),
    .GAP_CYCLES  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_cs      (cmd_cs),
    .cmd_rw      (cmd_rw),
    .cmd_data    (cmd_data),
    .spi_cs      (spi_cs),
    .spi_rw      (spi_rw),
    .spi_tx_data (spi_tx_data),
    .spi_rx_data (spi_rx_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_cs      (rsp_cs),
    .cmd_count   (cmd_count),
    .busy        (busy),
    .err_drop    (err_drop)
  );

  // Window monitor. In the last cycle of each window the auto slave returns tx^5A, so a capture on the wrong cycle yields 00.
  always @(negedge clk) begin
    if (spi_cs != 2'd0) begin
      if (run_len == 0) begin
        cur_w.cs  = spi_cs;
        cur_w.rw  = spi_rw;
        cur_w.tx  = spi_tx_data;
        cur_w.gap = idle_len;
        win_started++;
      end else if (spi_cs != cur_w.cs || spi_rw != cur_w.rw || spi_tx_data != cur_w.tx) begin
        unstable++;
      end
      run_len++;
      idle_len = 0;
    end else begin
      if (run_len != 0) begin
        cur_w.len = run_len;
        win_q.push_back(cur_w);
      end
      run_len = 0;
      idle_len++;
    end
    if (err_drop) err_seen++;
    rx_auto_val = (run_len == 8) ? (spi_tx_data ^ 8'h5A) : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int vld, input int cs, input int rw, input int dat, input int rrdy,
                     input int rx, input int ecs, input int erw, input int etx, input int erv,
                     input int erd, input int ercs, input int ecnt, input int ebusy,
                     input int eerr, input int ecrdy);
    vec_t v;
    v.vld = 1'(vld);   v.cs = 2'(cs);     v.rw = 2'(rw);     v.dat = 8'(dat);
    v.rrdy = 1'(rrdy); v.rx = 8'(rx);     v.e_cs = 2'(ecs);  v.e_rw = 2'(erw);
    v.e_tx = 8'(etx);  v.e_rv = 1'(erv);  v.e_rd = 8'(erd);  v.e_rcs = 2'(ercs);
    v.e_cnt = 3'(ecnt); v.e_busy = 1'(ebusy); v.e_err = 1'(eerr); v.e_crdy = 1'(ecrdy);
    tbl.push_back(v);
  endtask

  // Offer one command at a falling edge, wait (bounded) for cmd_ready, and return at the falling edge after acceptance.
  task automatic push(input int cs, input int rw, input int dat);
    win_t s;
    int n = 0;
    cmd_valid = 1'b1;
    cmd_cs    = 2'(cs);
    cmd_rw    = 2'(rw);
    cmd_data  = 8'(dat);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept_timeout", 32'(n < 200), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    s.cs = 2'(cs); s.rw = 2'(rw); s.tx = 8'(dat); s.len = 8; s.gap = 0;
    if (cs != 0) sent_q.push_back(s);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 400), 1);
  endtask

  initial begin
    int wbase;
    int sbase;
    int ebase;
    int n;

    reset = 1'b1; cmd_valid = 1'b0; cmd_cs = 2'd0; cmd_rw = 2'd0; cmd_data = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // After reset: everything is idle and zero, and the queue can accept.
    chk("rst_spi_cs", spi_cs, 0);
    chk("rst_spi_rw", spi_rw, 0);
    chk("rst_spi_tx_data", spi_tx_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_cs", rsp_cs, 0);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_drop", err_drop, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    reset = 1'b0;

    // Write cs=1 rw=01 A5: accept, IDLE, LOAD, 8 SHIFT, 2 GAP, IDLE.
    add(1,1,1,'hA5,0,0,   0,0,'h00,0,'h00,0,1,1,0,1);
    add(0,0,0,0,0,0,      0,0,'h00,0,'h00,0,1,1,0,1);
    for (int k = 0; k < 8; k++) add(0,0,0,0,0,0, 1,1,'hA5,0,'h00,0,0,1,0,1);
    add(0,0,0,0,0,0,      0,0,'hA5,0,'h00,0,0,1,0,1);
    add(0,0,0,0,0,0,      0,0,'hA5,0,'h00,0,0,1,0,1);
    add(0,0,0,0,0,0,      0,0,'hA5,0,'h00,0,0,0,0,1);
    // Read cs=2 rw=10 C3: rx=3C only in the last SHIFT cycle, E7 elsewhere.
    add(1,2,2,'hC3,0,'hE7, 0,0,'hA5,0,'h00,0,1,1,0,1);
    add(0,0,0,0,0,'hE7,   0,0,'hA5,0,'h00,0,1,1,0,1);
    for (int k = 0; k < 8; k++) add(0,0,0,0,0,'hE7, 2,2,'hC3,0,'h00,0,0,1,0,1);
    add(0,0,0,0,0,'h3C,   0,0,'hC3,0,'h00,0,0,1,0,1);
    add(0,0,0,0,0,'hE7,   0,0,'hC3,1,'h3C,2,0,1,0,1);
    add(0,0,0,0,0,'hE7,   0,0,'hC3,1,'h3C,2,0,1,0,1);
    add(0,0,0,0,0,'hE7,   0,0,'hC3,1,'h3C,2,0,0,0,1);
    add(0,0,0,0,0,'hE7,   0,0,'hC3,1,'h3C,2,0,0,0,1);
    add(0,0,0,0,1,'hE7,   0,0,'hC3,0,'h3C,2,0,0,0,1);
    add(0,0,0,0,0,'hE7,   0,0,'hC3,0,'h3C,2,0,0,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid = tbl[i].vld; cmd_cs = tbl[i].cs; cmd_rw = tbl[i].rw; cmd_data = tbl[i].dat;
      rsp_ready = tbl[i].rrdy; rx_man = tbl[i].rx;
      @(negedge clk);
      chk($sformatf("r%0d_spi_cs", i), spi_cs, tbl[i].e_cs);
      chk($sformatf("r%0d_spi_rw", i), spi_rw, tbl[i].e_rw);
      chk($sformatf("r%0d_spi_tx_data", i), spi_tx_data, tbl[i].e_tx);
      chk($sformatf("r%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
      chk($sformatf("r%0d_rsp_data", i), rsp_data, tbl[i].e_rd);
      chk($sformatf("r%0d_rsp_cs", i), rsp_cs, tbl[i].e_rcs);
      chk($sformatf("r%0d_cmd_count", i), cmd_count, tbl[i].e_cnt);
      chk($sformatf("r%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("r%0d_err_drop", i), err_drop, tbl[i].e_err);
      chk($sformatf("r%0d_cmd_ready", i), cmd_ready, tbl[i].e_crdy);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    rx_auto = 1'b1;

    // Five back-to-back commands with two reads and no consumer.
    wbase = win_q.size();
    sbase = sent_q.size();
    push(1, 1, 'h11);
    push(2, 2, 'h22);
    push(3, 3, 'h33);
    push(1, 0, 'h44);
    push(3, 1, 'h55);
    chk("t4_count_full", cmd_count, 4);
    chk("t4_ready_full", cmd_ready, 0);
    n = 0;
    while (!((win_q.size() - wbase) >= 3 && spi_cs == 2'd0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t4_third_window_timeout", 32'(n < 300), 1);
    repeat (20) @(negedge clk);
    #1;
    chk("t4_stall_windows", win_started - (wbase + 0) >= 0 ? win_q.size() - wbase : 0, 3);
    chk("t4_stall_spi_cs", spi_cs, 0);
    chk("t4_stall_run_len", run_len, 0);
    chk("t4_stall_rsp_valid", rsp_valid, 1);
    chk("t4_stall_rsp_data", rsp_data, 'h78);
    chk("t4_stall_rsp_cs", rsp_cs, 2);
    chk("t4_stall_count", cmd_count, 2);
    chk("t4_stall_busy", busy, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t4_reload_rsp_valid", rsp_valid, 1);
    chk("t4_reload_rsp_data", rsp_data, 'h69);
    chk("t4_reload_rsp_cs", rsp_cs, 3);
    wait_idle("t4_drain_timeout");
    @(negedge clk);
    chk("t4_window_total", win_q.size() - wbase, 5);
    if (win_q.size() - wbase == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("t4_w%0d_cs", k), win_q[wbase+k].cs, sent_q[sbase+k].cs);
        chk($sformatf("t4_w%0d_rw", k), win_q[wbase+k].rw, sent_q[sbase+k].rw);
        chk($sformatf("t4_w%0d_tx", k), win_q[wbase+k].tx, sent_q[sbase+k].tx);
        chk($sformatf("t4_w%0d_len", k), win_q[wbase+k].len, 8);
      end
      chk("t4_gap_after_write", win_q[wbase+1].gap, 4);
      chk("t4_gap_after_read", win_q[wbase+2].gap, 5);
      chk("t4_gap_after_rw00", win_q[wbase+4].gap, 4);
    end
    chk("t4_last_rsp_valid", rsp_valid, 1);
    chk("t4_last_rsp_data", rsp_data, 'h69);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t4_consumed", rsp_valid, 0);

    // A cs=0 command is dropped with one err_drop pulse, and the next command still runs.
    #1;
    wbase = win_q.size();
    ebase = err_seen;
    push(0, 1, 'hFF);
    chk("t5_err_t1", err_drop, 0);
    @(negedge clk);
    chk("t5_err_t2", err_drop, 0);
    chk("t5_count_t2", cmd_count, 1);
    @(negedge clk);
    chk("t5_err_t3", err_drop, 1);
    chk("t5_spi_cs_t3", spi_cs, 0);
    chk("t5_count_t3", cmd_count, 0);
    @(negedge clk);
    chk("t5_err_t4", err_drop, 0);
    push(2, 1, 'h5C);
    wait_idle("t5_drain_timeout");
    @(negedge clk);
    #1;
    chk("t5_err_pulses", err_seen - ebase, 1);
    chk("t5_windows", win_q.size() - wbase, 1);
    if (win_q.size() - wbase == 1) begin
      chk("t5_w_cs", win_q[wbase].cs, 2);
      chk("t5_w_tx", win_q[wbase].tx, 'h5C);
      chk("t5_w_len", win_q[wbase].len, 8);
    end
    chk("t5_rsp_valid", rsp_valid, 0);

    // Reset lands in the 4th SHIFT cycle of a window, with 2 commands queued and a response pending.
    sbase = win_started;
    push(1, 2, 'h70);
    push(1, 1, 'h61);
    push(2, 1, 'h62);
    push(3, 2, 'h63);
    n = 0;
    while (!((win_started - sbase) == 2 && run_len == 4) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t6_reach_timeout", 32'(n < 300), 1);
    chk("t6_pre_count", cmd_count, 2);
    chk("t6_pre_rsp_valid", rsp_valid, 1);
    chk("t6_pre_rsp_data", rsp_data, 'h2A);
    chk("t6_pre_spi_cs", spi_cs, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_spi_cs", spi_cs, 0);
    chk("t6_spi_tx_data", spi_tx_data, 0);
    chk("t6_count", cmd_count, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("t6_no_more_windows", win_started - sbase, 2);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_rsp_valid", rsp_valid, 0);

    chk("window_fields_stable", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so a stuck run still ends with a failure report.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
